// File: rtl/sme_pkg.sv
// Shared opcode, FSM state and operation-class definitions for the masked ALU sequencer.
package sme_pkg;

    typedef enum logic [3:0] {
        OP_XOR    = 4'd0,
        OP_XNOR   = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_ANDN   = 4'd4,
        OP_ORN    = 4'd5,
        OP_ADD    = 4'd6,
        OP_SUB    = 4'd7,
        OP_SLL    = 4'd8,
        OP_SRL    = 4'd9,
        OP_ROR    = 4'd10,
        OP_NOT    = 4'd11,
        OP_MOV    = 4'd12,
        OP_MASK   = 4'd13,
        OP_REMASK = 4'd14,
        OP_UNMASK = 4'd15
    } sme_op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RNG = 2'd1,
        ST_EXEC     = 2'd2,
        ST_RESP     = 2'd3
    } sme_state_t;

    // Nonlinear ops mix shares and need a fresh guard-share word from the RNG.
    function automatic logic sme_is_nonlinear(input sme_op_t op);
        return op inside {OP_AND, OP_OR, OP_ANDN, OP_ORN, OP_ADD, OP_SUB, OP_MASK, OP_REMASK};
    endfunction

endpackage

// File: rtl/sme_alu_ctrl.sv
// Masked-ALU sequencer: latches one request, waits for fresh RNG on nonlinear ops, runs the external ALU, holds the result.
// Latency >= 2 cycles accept-to-response; req_ready only in IDLE, result held until rsp_ready, watchdog aborts a stalled ALU.
module sme_alu_ctrl
    import sme_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SMAX = 4,
    parameter int WDOG = 15,
    localparam int SW  = SMAX * XLEN - 1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_shamt,
    input  logic [SW:0] req_rs1,
    input  logic [SW:0] req_rs2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [SW:0] rsp_rd,
    output logic        rsp_err,
    output logic        alu_valid,
    input  logic        alu_ready,
    output logic [3:0]  alu_op,
    output logic [4:0]  alu_shamt,
    output logic [SW:0] alu_rs1,
    output logic [SW:0] alu_rs2,
    input  logic [SW:0] alu_rd,
    input  logic        rng_fresh,
    output logic        rng_consume
);

    localparam logic [3:0] WDOG_LAST = 4'(WDOG - 1);

    sme_state_t  r_state;
    logic [3:0]  r_alu_op;
    logic [4:0]  r_alu_shamt;
    logic [SW:0] r_alu_rs1;
    logic [SW:0] r_alu_rs2;
    logic [SW:0] r_rsp_rd;
    logic        r_rsp_err;
    logic [3:0]  r_wdog;

    logic w_nonlin;
    logic w_done;

    assign w_nonlin    = sme_is_nonlinear(sme_op_t'(r_alu_op));
    assign w_done      = (r_state == ST_EXEC) && alu_ready && !flush;

    assign req_ready   = (r_state == ST_IDLE) && !flush;
    assign alu_valid   = (r_state == ST_EXEC);
    assign rsp_valid   = (r_state == ST_RESP);
    assign rng_consume = w_done && w_nonlin;

    assign alu_op      = r_alu_op;
    assign alu_shamt   = r_alu_shamt;
    assign alu_rs1     = r_alu_rs1;
    assign alu_rs2     = r_alu_rs2;
    assign rsp_rd      = r_rsp_rd;
    assign rsp_err     = r_rsp_err;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state     <= ST_IDLE;
            r_alu_op    <= '0;
            r_alu_shamt <= '0;
            r_alu_rs1   <= '0;
            r_alu_rs2   <= '0;
            r_rsp_rd    <= '0;
            r_rsp_err   <= 1'b0;
            r_wdog      <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_alu_op    <= req_op;
                        r_alu_shamt <= req_shamt;
                        r_alu_rs1   <= req_rs1;
                        r_alu_rs2   <= req_rs2;
                        r_wdog      <= '0;
                        r_state     <= (!sme_is_nonlinear(sme_op_t'(req_op)) || rng_fresh)
                                       ? ST_EXEC : ST_WAIT_RNG;
                    end
                end
                ST_WAIT_RNG: begin
                    if (rng_fresh) begin
                        r_wdog  <= '0;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // A result arriving on the last watchdog cycle still counts as a completion.
                    if (alu_ready) begin
                        r_rsp_rd  <= alu_rd;
                        r_rsp_err <= 1'b0;
                        r_state   <= ST_RESP;
                    end else begin
                        r_wdog <= r_wdog + 4'd1;
                        if (r_wdog == WDOG_LAST) begin
                            r_rsp_rd  <= '0;
                            r_rsp_err <= 1'b1;
                            r_state   <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
